// File: rtl/m_seq_store_serializer.sv
`timescale 1ns/1ps
// m_seq_store_serializer
// Takes the wide sequential beats coming out of the matrix deshuffle stage
// and slices each one into MemDataWidth-wide memory write beats with byte
// strobes and incrementing byte addresses. Per-request descriptors are
// buffered in a small meta queue, and one done pulse is issued per request.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   meta_valid_i / meta_ready_o   descriptor handshake
//   meta_addr_i                   request base byte address (beat aligned)
//   meta_beats_i                  number of input beats in the request (>=1)
//   meta_req_id_i                 request id, echoed on completion
//   seq_valid_i / seq_ready_o     sequential beat handshake
//   seq_nb_i, seq_en_i            beat data and per-nibble enables
//   wr_valid_o / wr_ready_i       write beat handshake
//   wr_addr_o, wr_data_o          write byte address and data
//   wr_strb_o                     write byte strobes
//   done_valid_o, done_req_id_o   one-cycle completion pulse and its id
//   err_o                         sticky flag: nibble pair with mismatched enables
module m_seq_store_serializer #(
  parameter int NrExits      = 4,
  parameter int DLEN         = 64,
  parameter int MemDataWidth = 64,
  parameter int AddrWidth    = 32,
  parameter int ReqIdWidth   = 4,
  parameter int MetaDepth    = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           meta_valid_i,
  output logic                           meta_ready_o,
  input  logic [AddrWidth-1:0]           meta_addr_i,
  input  logic [15:0]                    meta_beats_i,
  input  logic [ReqIdWidth-1:0]          meta_req_id_i,
  input  logic                           seq_valid_i,
  output logic                           seq_ready_o,
  input  logic [NrExits*DLEN-1:0]        seq_nb_i,
  input  logic [NrExits*DLEN/4-1:0]      seq_en_i,
  output logic                           wr_valid_o,
  input  logic                           wr_ready_i,
  output logic [AddrWidth-1:0]           wr_addr_o,
  output logic [MemDataWidth-1:0]        wr_data_o,
  output logic [MemDataWidth/8-1:0]      wr_strb_o,
  output logic                           done_valid_o,
  output logic [ReqIdWidth-1:0]          done_req_id_o,
  output logic                           err_o
);

  localparam int BeatW       = NrExits*DLEN;
  localparam int EnW         = BeatW/4;
  localparam int K           = BeatW/MemDataWidth;
  localparam int StrbW       = MemDataWidth/8;
  localparam int NibPerSlice = MemDataWidth/4;
  localparam int SubW        = (K > 1) ? $clog2(K) : 1;
  localparam int PtrW        = $clog2(MetaDepth);
  localparam int ByteShift   = $clog2(StrbW);

  localparam logic [SubW-1:0] LastSub  = SubW'(K-1);
  localparam logic [PtrW:0]   PtrOne   = (PtrW+1)'(1);
  localparam logic [PtrW:0]   CountTwo = (PtrW+1)'(2);

  typedef enum logic {StIdle, StSer} state_t;

  state_t                 r_state, w_nextState;

  logic [AddrWidth-1:0]   r_qAddr  [MetaDepth];
  logic [15:0]            r_qBeats [MetaDepth];
  logic [ReqIdWidth-1:0]  r_qId    [MetaDepth];
  logic [PtrW:0]          r_wrPtr, r_rdPtr;

  logic [BeatW-1:0]       r_nb;
  logic [EnW-1:0]         r_en;
  logic [SubW-1:0]        r_sub;
  logic [15:0]            r_beatCnt;
  logic [AddrWidth-1:0]   r_cnt;
  logic                   r_err;
  logic                   r_doneValid;
  logic [ReqIdWidth-1:0]  r_doneId;

  logic [PtrW:0]          w_count;
  logic                   w_empty, w_full, w_metaEnq;
  logic [AddrWidth-1:0]   w_headAddr;
  logic [15:0]            w_headBeats;
  logic [ReqIdWidth-1:0]  w_headId;
  logic [MemDataWidth-1:0] w_dataSlice;
  logic [NibPerSlice-1:0] w_enSlice;
  logic [StrbW-1:0]       w_strb;
  logic                   w_pairMismatch;
  logic                   w_inSer, w_skip, w_subDone, w_lastSub, w_lastBeat;
  logic                   w_beatDone, w_reqDone, w_seqReady, w_seqAccept;

  // Queue occupancy from flag+index pointers: equal indices with differing
  // flags means full. meta_ready_o is forced low while reset is held.
  assign w_count      = r_wrPtr - r_rdPtr;
  assign w_empty      = (r_wrPtr == r_rdPtr);
  assign w_full       = (r_wrPtr[PtrW] != r_rdPtr[PtrW]) &&
                        (r_wrPtr[PtrW-1:0] == r_rdPtr[PtrW-1:0]);
  assign meta_ready_o = !w_full && !rst_i;
  assign w_metaEnq    = meta_valid_i && !w_full;
  assign w_headAddr   = r_qAddr[r_rdPtr[PtrW-1:0]];
  assign w_headBeats  = r_qBeats[r_rdPtr[PtrW-1:0]];
  assign w_headId     = r_qId[r_rdPtr[PtrW-1:0]];

  // Pick the current sub-beat slice of the held beat and its nibble enables.
  always_comb begin
    w_dataSlice = '0;
    w_enSlice   = '0;
    for (int k = 0; k < K; k++) begin
      if (r_sub == SubW'(k)) begin
        w_dataSlice = r_nb[k*MemDataWidth +: MemDataWidth];
        w_enSlice   = r_en[k*NibPerSlice +: NibPerSlice];
      end
    end
  end

  // A byte is written if either of its nibbles is enabled; a pair that
  // disagrees is still written whole but flags an error.
  always_comb begin
    w_strb         = '0;
    w_pairMismatch = 1'b0;
    for (int b = 0; b < StrbW; b++) begin
      w_strb[b]      = w_enSlice[2*b] | w_enSlice[2*b+1];
      w_pairMismatch = w_pairMismatch | (w_enSlice[2*b] ^ w_enSlice[2*b+1]);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StIdle;
    else       r_state <= w_nextState;
  end

  // Next-state and handshake logic. A new beat may be taken in the same
  // cycle the last sub-beat finishes, but only if a descriptor will still be
  // available for it after the current request possibly retires.
  always_comb begin
    w_nextState = r_state;
    w_inSer     = (r_state == StSer);
    w_skip      = w_inSer && (w_strb == '0);
    wr_valid_o  = w_inSer && !w_skip;
    w_subDone   = w_inSer && (w_skip || wr_ready_i);
    w_lastSub   = (r_sub == LastSub);
    w_lastBeat  = (r_beatCnt == (w_headBeats - 16'd1));
    w_beatDone  = w_subDone && w_lastSub;
    w_reqDone   = w_beatDone && w_lastBeat;
    w_seqReady  = 1'b0;
    case (r_state)
      StIdle:  w_seqReady = !w_empty;
      StSer:   w_seqReady = w_beatDone && (w_lastBeat ? (w_count >= CountTwo) : 1'b1);
      default: w_seqReady = 1'b0;
    endcase
    w_seqAccept = seq_valid_i && w_seqReady;
    case (r_state)
      StIdle:  if (w_seqAccept) w_nextState = StSer;
      StSer:   if (w_beatDone && !w_seqAccept) w_nextState = StIdle;
      default: w_nextState = StIdle;
    endcase
  end

  assign seq_ready_o   = w_seqReady;
  assign wr_data_o     = w_dataSlice;
  assign wr_strb_o     = w_strb;
  assign wr_addr_o     = w_headAddr + (r_cnt << ByteShift);
  assign done_valid_o  = r_doneValid;
  assign done_req_id_o = r_doneId;
  assign err_o         = r_err;

  // Meta queue storage and pointers; the head retires when its request ends.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < MetaDepth; i++) begin
        r_qAddr[i]  <= '0;
        r_qBeats[i] <= '0;
        r_qId[i]    <= '0;
      end
    end else begin
      if (w_metaEnq) begin
        r_qAddr[r_wrPtr[PtrW-1:0]]  <= meta_addr_i;
        r_qBeats[r_wrPtr[PtrW-1:0]] <= meta_beats_i;
        r_qId[r_wrPtr[PtrW-1:0]]    <= meta_req_id_i;
        r_wrPtr <= r_wrPtr + PtrOne;
      end
      if (w_reqDone) r_rdPtr <= r_rdPtr + PtrOne;
    end
  end

  // Holding register, sub-beat / input-beat / address counters, error flag
  // and completion pulse. Skipped sub-beats still advance the address count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_nb        <= '0;
      r_en        <= '0;
      r_sub       <= '0;
      r_beatCnt   <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_doneValid <= 1'b0;
      r_doneId    <= '0;
    end else begin
      if (w_seqAccept) begin
        r_nb  <= seq_nb_i;
        r_en  <= seq_en_i;
        r_sub <= '0;
      end else if (w_subDone && !w_lastSub) begin
        r_sub <= r_sub + SubW'(1);
      end
      if (w_reqDone)       r_cnt <= '0;
      else if (w_subDone)  r_cnt <= r_cnt + AddrWidth'(1);
      if (w_reqDone)       r_beatCnt <= '0;
      else if (w_beatDone) r_beatCnt <= r_beatCnt + 16'd1;
      if (w_inSer && w_pairMismatch) r_err <= 1'b1;
      r_doneValid <= w_reqDone;
      if (w_reqDone) r_doneId <= w_headId;
    end
  end

endmodule

// File: tb/tb_m_seq_store_serializer.sv
`timescale 1ns/1ps
// Directed testbench for m_seq_store_serializer with default parameters
// (256-bit input beats split into four 64-bit write beats).
module tb_m_seq_store_serializer;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          meta_valid_i;
  logic          meta_ready_o;
  logic [31:0]   meta_addr_i;
  logic [15:0]   meta_beats_i;
  logic [3:0]    meta_req_id_i;
  logic          seq_valid_i;
  logic          seq_ready_o;
  logic [255:0]  seq_nb_i;
  logic [63:0]   seq_en_i;
  logic          wr_valid_o;
  logic          wr_ready_i;
  logic [31:0]   wr_addr_o;
  logic [63:0]   wr_data_o;
  logic [7:0]    wr_strb_o;
  logic          done_valid_o;
  logic [3:0]    done_req_id_o;
  logic          err_o;

  int total = 0;
  int bad   = 0;

  m_seq_store_serializer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .meta_valid_i(meta_valid_i), .meta_ready_o(meta_ready_o),
    .meta_addr_i(meta_addr_i), .meta_beats_i(meta_beats_i), .meta_req_id_i(meta_req_id_i),
    .seq_valid_i(seq_valid_i), .seq_ready_o(seq_ready_o),
    .seq_nb_i(seq_nb_i), .seq_en_i(seq_en_i),
    .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .wr_strb_o(wr_strb_o),
    .done_valid_o(done_valid_o), .done_req_id_o(done_req_id_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Recognisable 64-bit slice value tagged with the beat tag and slice index.
  function automatic logic [63:0] sliceVal(input int tag, input int s);
    return {tag[7:0], s[7:0], 48'h5A5A_0F0F_3C3C};
  endfunction

  function automatic logic [255:0] makeNb(input int tag);
    logic [255:0] v;
    for (int s = 0; s < 4; s++) v[s*64 +: 64] = sliceVal(tag, s);
    return v;
  endfunction

  // Hold reset for two cycles with all inputs idle, release on a falling edge.
  task automatic doReset();
    rst_i = 1'b1;
    meta_valid_i = 1'b0; meta_addr_i = '0; meta_beats_i = '0; meta_req_id_i = '0;
    seq_valid_i = 1'b0; seq_nb_i = '0; seq_en_i = '0; wr_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Offer one descriptor and wait (bounded) until it is taken.
  task automatic pushMeta(input logic [31:0] addr, input logic [15:0] beats, input logic [3:0] id);
    int waitCnt;
    @(negedge clk_i);
    meta_valid_i = 1'b1; meta_addr_i = addr; meta_beats_i = beats; meta_req_id_i = id;
    #1;
    waitCnt = 0;
    while (!meta_ready_o && waitCnt < 20) begin
      @(negedge clk_i); #1; waitCnt++;
    end
    total++;
    if (meta_ready_o !== 1'b1) begin
      bad++; $display("[TB] FAIL meta_push_timeout got=%b exp=1", meta_ready_o);
    end
    @(posedge clk_i); #1;
    meta_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    meta_valid_i = 1'b0; meta_addr_i = 32'hDEAD_BEEF; meta_beats_i = 16'd1; meta_req_id_i = 4'hF;
    seq_valid_i = 1'b1; seq_nb_i = '1; seq_en_i = '1; wr_ready_i = 1'b1;
    rst_i = 1'b1;
    #1;
    total++;
    if ({meta_ready_o, seq_ready_o, wr_valid_o, done_valid_o, err_o} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got=%b exp=00000",
                      {meta_ready_o, seq_ready_o, wr_valid_o, done_valid_o, err_o});
    end
    total++;
    if ({wr_addr_o, wr_data_o, wr_strb_o, done_req_id_o} !== 108'b0) begin
      bad++; $display("[TB] FAIL reset_data got=%h exp=0", {wr_addr_o, wr_data_o, wr_strb_o, done_req_id_o});
    end
    doReset();
    #1;
    total++;
    if ({meta_ready_o, seq_ready_o} !== 2'b10) begin
      bad++; $display("[TB] FAIL after_reset_ready got=%b exp=10", {meta_ready_o, seq_ready_o});
    end
  endtask

  // One descriptor of one beat; skipIdx selects a slice whose enables are all
  // zero (-1 for none). The skipped slice occupies a cycle without a write.
  task automatic test_single_beat(input int skipIdx);
    logic [63:0] en;
    logic [31:0] expAddr;
    logic        expValid;
    doReset();
    pushMeta(32'h1000, 16'd1, 4'd3);
    en = '1;
    if (skipIdx >= 0) en[skipIdx*16 +: 16] = '0;
    @(negedge clk_i);
    seq_valid_i = 1'b1; seq_nb_i = makeNb(1); seq_en_i = en; wr_ready_i = 1'b1;
    #1;
    total++;
    if (seq_ready_o !== 1'b1) begin
      bad++; $display("[TB] FAIL single_seq_ready skip=%0d got=%b exp=1", skipIdx, seq_ready_o);
    end
    @(negedge clk_i);
    seq_valid_i = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk_i);
      #1;
      expValid = (s != skipIdx);
      expAddr  = 32'h1000 + 32'(s*8);
      total++;
      if (wr_valid_o !== expValid) begin
        bad++; $display("[TB] FAIL single_valid skip=%0d s=%0d got=%b exp=%b", skipIdx, s, wr_valid_o, expValid);
      end
      if (expValid) begin
        total++;
        if ({wr_addr_o, wr_data_o, wr_strb_o} !== {expAddr, sliceVal(1, s), 8'hFF}) begin
          bad++; $display("[TB] FAIL single_beat skip=%0d s=%0d got=%h/%h/%h exp=%h/%h/ff",
                          skipIdx, s, wr_addr_o, wr_data_o, wr_strb_o, expAddr, sliceVal(1, s));
        end
      end
      total++;
      if (done_valid_o !== 1'b0) begin
        bad++; $display("[TB] FAIL single_early_done skip=%0d s=%0d got=%b exp=0", skipIdx, s, done_valid_o);
      end
    end
    @(negedge clk_i); #1;
    total++;
    if ({done_valid_o, done_req_id_o, wr_valid_o} !== {1'b1, 4'd3, 1'b0}) begin
      bad++; $display("[TB] FAIL single_done skip=%0d got=%b/%0d/%b exp=1/3/0",
                      skipIdx, done_valid_o, done_req_id_o, wr_valid_o);
    end
    @(negedge clk_i); #1;
    total++;
    if (done_valid_o !== 1'b0) begin
      bad++; $display("[TB] FAIL single_done_width skip=%0d got=%b exp=0", skipIdx, done_valid_o);
    end
  endtask

  // Two 2-beat descriptors, seq_valid offered until four beats are taken:
  // sixteen back-to-back writes, done after write 8 (id 1) and 16 (id 2).
  task automatic test_back_to_back();
    int          accepts;
    int          j;
    logic [31:0] expAddr;
    doReset();
    pushMeta(32'h0000, 16'd2, 4'd1);
    pushMeta(32'h2000, 16'd2, 4'd2);
    accepts = 0;
    wr_ready_i = 1'b1;
    seq_en_i = '1;
    for (int c = 0; c <= 17; c++) begin
      @(negedge clk_i);
      seq_valid_i = (accepts < 4);
      seq_nb_i = makeNb(accepts);
      #1;
      if (c >= 1 && c <= 16) begin
        j = c - 1;
        expAddr = ((j >= 8) ? 32'h2000 : 32'h0) + 32'((j % 8) * 8);
        total++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, expAddr, sliceVal(j / 4, j % 4)}) begin
          bad++; $display("[TB] FAIL b2b_beat c=%0d got=%b/%h/%h exp=1/%h/%h",
                          c, wr_valid_o, wr_addr_o, wr_data_o, expAddr, sliceVal(j / 4, j % 4));
        end
      end else begin
        total++;
        if (wr_valid_o !== 1'b0) begin
          bad++; $display("[TB] FAIL b2b_idle c=%0d got=%b exp=0", c, wr_valid_o);
        end
      end
      total++;
      if (c == 9 || c == 17) begin
        if ({done_valid_o, done_req_id_o} !== {1'b1, (c == 9) ? 4'd1 : 4'd2}) begin
          bad++; $display("[TB] FAIL b2b_done c=%0d got=%b/%0d exp=1/%0d",
                          c, done_valid_o, done_req_id_o, (c == 9) ? 1 : 2);
        end
      end else if (done_valid_o !== 1'b0) begin
        bad++; $display("[TB] FAIL b2b_spurious_done c=%0d got=%b exp=0", c, done_valid_o);
      end
      if (c <= 8) begin
        total++;
        if (meta_ready_o !== 1'b0) begin
          bad++; $display("[TB] FAIL b2b_meta_full c=%0d got=%b exp=0", c, meta_ready_o);
        end
      end
      if (seq_valid_i && seq_ready_o) accepts++;
    end
    total++;
    if (accepts != 4) begin
      bad++; $display("[TB] FAIL b2b_accepts got=%0d exp=4", accepts);
    end
  endtask

  // Write ready toggling 1,0,1,0...: outputs hold while stalled and the next
  // input beat is taken only in the cycle the fourth sub-beat handshakes.
  task automatic test_stall();
    int   accepts;
    int   expCnt;
    int   k;
    logic expSeqReady;
    logic [31:0] expAddr;
    doReset();
    pushMeta(32'h3000, 16'd2, 4'd5);
    @(negedge clk_i);
    seq_valid_i = 1'b1; seq_nb_i = makeNb(2); seq_en_i = '1; wr_ready_i = 1'b0;
    #1;
    total++;
    if (seq_ready_o !== 1'b1) begin
      bad++; $display("[TB] FAIL stall_first_ready got=%b exp=1", seq_ready_o);
    end
    accepts = 1;
    expCnt = 0;
    k = 0;
    while (expCnt < 8 && k < 40) begin
      @(negedge clk_i);
      wr_ready_i = (k % 2 == 0);
      seq_valid_i = (accepts < 2);
      #1;
      expAddr = 32'h3000 + 32'(expCnt * 8);
      total++;
      if ({wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o} !== {1'b1, expAddr, sliceVal(2, expCnt % 4), 8'hFF}) begin
        bad++; $display("[TB] FAIL stall_hold k=%0d got=%b/%h/%h/%h exp=1/%h/%h/ff",
                        k, wr_valid_o, wr_addr_o, wr_data_o, wr_strb_o, expAddr, sliceVal(2, expCnt % 4));
      end
      expSeqReady = (expCnt == 3) && wr_ready_i;
      total++;
      if (seq_ready_o !== expSeqReady) begin
        bad++; $display("[TB] FAIL stall_seq_ready k=%0d got=%b exp=%b", k, seq_ready_o, expSeqReady);
      end
      if (seq_valid_i && seq_ready_o) accepts++;
      if (wr_ready_i) expCnt++;
      k++;
    end
    total++;
    if (expCnt != 8) begin
      bad++; $display("[TB] FAIL stall_timeout got=%0d exp=8", expCnt);
    end
    @(negedge clk_i);
    wr_ready_i = 1'b0;
    #1;
    total++;
    if ({done_valid_o, done_req_id_o} !== {1'b1, 4'd5}) begin
      bad++; $display("[TB] FAIL stall_done got=%b/%0d exp=1/5", done_valid_o, done_req_id_o);
    end
  endtask

  // Nibble 0 on, nibble 1 off (mismatch), byte 1 fully off: strobe 0xFD,
  // error rises and stays through a clean second beat until reset.
  task automatic test_err();
    doReset();
    pushMeta(32'h4000, 16'd2, 4'd7);
    @(negedge clk_i);
    seq_valid_i = 1'b1; seq_nb_i = makeNb(3); seq_en_i = {48'hFFFF_FFFF_FFFF, 16'hFFF1}; wr_ready_i = 1'b1;
    @(negedge clk_i);
    seq_nb_i = makeNb(4); seq_en_i = '1;
    #1;
    total++;
    if ({wr_valid_o, wr_addr_o, wr_strb_o} !== {1'b1, 32'h4000, 8'hFD}) begin
      bad++; $display("[TB] FAIL err_strb got=%b/%h/%h exp=1/00004000/fd", wr_valid_o, wr_addr_o, wr_strb_o);
    end
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      if (i == 4) seq_valid_i = 1'b0;
      #1;
      total++;
      if (err_o !== 1'b1) begin
        bad++; $display("[TB] FAIL err_sticky i=%0d got=%b exp=1", i, err_o);
      end
      if (i >= 4 && i <= 7) begin
        total++;
        if ({wr_valid_o, wr_strb_o} !== {1'b1, 8'hFF}) begin
          bad++; $display("[TB] FAIL err_clean_strb i=%0d got=%b/%h exp=1/ff", i, wr_valid_o, wr_strb_o);
        end
      end
      if (i == 8) begin
        total++;
        if ({done_valid_o, done_req_id_o} !== {1'b1, 4'd7}) begin
          bad++; $display("[TB] FAIL err_done got=%b/%0d exp=1/7", done_valid_o, done_req_id_o);
        end
      end
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    total++;
    if (err_o !== 1'b0) begin
      bad++; $display("[TB] FAIL err_clear got=%b exp=0", err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // Address wrap past 2^32, then reset while the third write is stalled.
  task automatic test_wrap_reset();
    doReset();
    pushMeta(32'hFFFF_FFF0, 16'd1, 4'd9);
    @(negedge clk_i);
    seq_valid_i = 1'b1; seq_nb_i = makeNb(6); seq_en_i = '1; wr_ready_i = 1'b1;
    @(negedge clk_i);
    seq_valid_i = 1'b0;
    #1;
    total++;
    if (wr_addr_o !== 32'hFFFF_FFF0) begin
      bad++; $display("[TB] FAIL wrap_addr0 got=%h exp=fffffff0", wr_addr_o);
    end
    @(negedge clk_i); #1;
    total++;
    if (wr_addr_o !== 32'hFFFF_FFF8) begin
      bad++; $display("[TB] FAIL wrap_addr1 got=%h exp=fffffff8", wr_addr_o);
    end
    @(negedge clk_i);
    wr_ready_i = 1'b0;
    #1;
    total++;
    if ({wr_valid_o, wr_addr_o} !== {1'b1, 32'h0}) begin
      bad++; $display("[TB] FAIL wrap_addr2 got=%b/%h exp=1/00000000", wr_valid_o, wr_addr_o);
    end
    @(negedge clk_i); #1;
    total++;
    if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, 32'h0, sliceVal(6, 2)}) begin
      bad++; $display("[TB] FAIL wrap_stall_hold got=%b/%h/%h exp=1/00000000/%h",
                      wr_valid_o, wr_addr_o, wr_data_o, sliceVal(6, 2));
    end
    #2;
    rst_i = 1'b1;
    #1;
    total++;
    if ({meta_ready_o, seq_ready_o, wr_valid_o, done_valid_o, err_o,
         wr_addr_o, wr_data_o, wr_strb_o, done_req_id_o} !== 113'b0) begin
      bad++; $display("[TB] FAIL wrap_reset_outputs got=%h exp=0",
                      {meta_ready_o, seq_ready_o, wr_valid_o, done_valid_o, err_o,
                       wr_addr_o, wr_data_o, wr_strb_o, done_req_id_o});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    wr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i); #1;
      total++;
      if ({done_valid_o, wr_valid_o} !== 2'b00) begin
        bad++; $display("[TB] FAIL wrap_no_done i=%0d got=%b exp=00", i, {done_valid_o, wr_valid_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat(-1);
    test_single_beat(1);
    test_back_to_back();
    test_stall();
    test_err();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
